cw305_mailbox_fifo: RTL

Parametrised, bidirectional word mailbox between the CW305 host register interface (USB side) and the PULPino core's data port. It has two circular FIFOs. The host pushes words into the host-to-core (H2C) FIFO and pops words from the core-to-host (C2H) FIFO through byte-wide register accesses. The core side uses valid/ready handshakes. It replaces the fixed single-word READ_DATA/WRITE_DATA/DATA_CTRL/DATA_STATUS registers with configurable width and depth, occupancy counts and sticky error flags.

---
 rtl/cw305_mailbox_fifo_if.sv | 31 +++
 rtl/cw305_mailbox_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cw305_mailbox_fifo_if.sv
// Core-side word handshake of the CW305 mailbox.
// master: mailbox side, slave: core side.
`timescale 1ns/1ps
interface cw305_mailbox_fifo_if #(
  parameter int pDATA_WIDTH = 32
);
  logic [pDATA_WIDTH-1:0] h2c_data_o;
  logic                   h2c_valid_o;
  logic                   h2c_ready_i;
  logic [pDATA_WIDTH-1:0] c2h_data_i;
  logic                   c2h_valid_i;
  logic                   c2h_ready_o;

  modport master (
    output h2c_data_o,
    output h2c_valid_o,
    input  h2c_ready_i,
    input  c2h_data_i,
    input  c2h_valid_i,
    output c2h_ready_o
  );

  modport slave (
    input  h2c_data_o,
    input  h2c_valid_o,
    output h2c_ready_i,
    output c2h_data_i,
    output c2h_valid_i,
    input  c2h_ready_o
  );
endinterface

// File: rtl/cw305_mailbox_fifo.sv
// Bidirectional word mailbox: byte-wide host registers on one side,
// valid/ready core handshake on the other, one circular FIFO per direction.
`timescale 1ns/1ps
module cw305_mailbox_fifo #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pDATA_WIDTH   = 32,
  parameter int pDEPTH        = 8,
  parameter int pREG_H2C_DATA = 'h10,
  parameter int pREG_H2C_PUSH = 'h11,
  parameter int pREG_C2H_DATA = 'h12,
  parameter int pREG_C2H_POP  = 'h13,
  parameter int pREG_STATUS   = 'h14
) (
  input  logic usb_clk,
  input  logic reset_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic reg_read,
  input  logic reg_write,
  input  logic reg_addrvalid,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  cw305_mailbox_fifo_if.master core
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int NB = pDATA_WIDTH / 8;
  localparam int PW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] A_H2C_DATA = AW'(pREG_H2C_DATA);
  localparam logic [AW-1:0] A_H2C_PUSH = AW'(pREG_H2C_PUSH);
  localparam logic [AW-1:0] A_C2H_DATA = AW'(pREG_C2H_DATA);
  localparam logic [AW-1:0] A_C2H_POP  = AW'(pREG_C2H_POP);
  localparam logic [AW-1:0] A_STATUS   = AW'(pREG_STATUS);
  localparam logic [CW-1:0] FULL       = CW'(pDEPTH);

  logic [pDATA_WIDTH-1:0] h2c_mem [pDEPTH];
  logic [pDATA_WIDTH-1:0] c2h_mem [pDEPTH];
  logic [PW-1:0] h2c_head, h2c_tail;
  logic [PW-1:0] c2h_head, c2h_tail;
  logic [CW-1:0] h2c_cnt, c2h_cnt;
  logic [pDATA_WIDTH-1:0] stage;
  logic ovf, unf;

  logic host_wr, wr_stage, wr_push, wr_pop, wr_status;
  logic flush, clr_ovf, clr_unf;
  logic h2c_empty, h2c_full, c2h_empty, c2h_full;
  logic h2c_in, h2c_out, c2h_in, c2h_out;
  logic ovf_set, unf_set;
  logic sel_c2h, sel_h2c, sel_st;
  logic [pDATA_WIDTH-1:0] c2h_head_word;
  logic [7:0] rd_byte;

  assign host_wr   = reg_addrvalid & reg_write;
  assign wr_stage  = host_wr & (reg_address == A_H2C_DATA);
  assign wr_push   = host_wr & (reg_address == A_H2C_PUSH);
  assign wr_pop    = host_wr & (reg_address == A_C2H_POP);
  assign wr_status = host_wr & (reg_address == A_STATUS)
                   & (reg_bytecnt == '0);

  assign flush   = wr_status & write_data[7];
  assign clr_ovf = wr_status & write_data[4];
  assign clr_unf = wr_status & write_data[5];

  assign h2c_empty = (h2c_cnt == '0);
  assign h2c_full  = (h2c_cnt == FULL);
  assign c2h_empty = (c2h_cnt == '0);
  assign c2h_full  = (c2h_cnt == FULL);

  // Fullness is judged on registered state, so a same-cycle core pop
  // never makes room for a host push.
  assign h2c_in  = wr_push & ~h2c_full & ~flush;
  assign h2c_out = ~h2c_empty & core.h2c_ready_i & ~flush;
  assign c2h_in  = core.c2h_valid_i & ~c2h_full & ~flush;
  assign c2h_out = wr_pop & ~c2h_empty & ~flush;
  assign ovf_set = wr_push & h2c_full & ~flush;
  assign unf_set = wr_pop & c2h_empty & ~flush;

  assign core.h2c_valid_o = ~h2c_empty;
  assign core.h2c_data_o  = h2c_empty ? '0 : h2c_mem[h2c_head];
  assign core.c2h_ready_o = ~c2h_full;

  assign c2h_head_word = c2h_mem[c2h_head];

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pDEPTH; i++) h2c_mem[i] <= '0;
    end else if (h2c_in) begin
      h2c_mem[h2c_tail] <= stage;
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pDEPTH; i++) c2h_mem[i] <= '0;
    end else if (c2h_in) begin
      c2h_mem[c2h_tail] <= core.c2h_data_i;
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      h2c_head <= '0;
      h2c_tail <= '0;
      h2c_cnt  <= '0;
    end else if (flush) begin
      h2c_head <= '0;
      h2c_tail <= '0;
      h2c_cnt  <= '0;
    end else begin
      if (h2c_in)  h2c_tail <= h2c_tail + PW'(1);
      if (h2c_out) h2c_head <= h2c_head + PW'(1);
      h2c_cnt <= h2c_cnt + CW'(h2c_in) - CW'(h2c_out);
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      c2h_head <= '0;
      c2h_tail <= '0;
      c2h_cnt  <= '0;
    end else if (flush) begin
      c2h_head <= '0;
      c2h_tail <= '0;
      c2h_cnt  <= '0;
    end else begin
      if (c2h_in)  c2h_tail <= c2h_tail + PW'(1);
      if (c2h_out) c2h_head <= c2h_head + PW'(1);
      c2h_cnt <= c2h_cnt + CW'(c2h_in) - CW'(c2h_out);
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else if (wr_stage) begin
      for (int b = 0; b < NB; b++) begin
        if (int'(reg_bytecnt) == b) stage[8*b +: 8] <= write_data;
      end
    end
  end

  // A set in the same cycle as its clear wins.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~clr_ovf);
      unf <= unf_set | (unf & ~clr_unf);
    end
  end

  assign sel_c2h = (reg_address == A_C2H_DATA);
  assign sel_h2c = (reg_address == A_H2C_DATA);
  assign sel_st  = (reg_address == A_STATUS);

  always_comb begin
    rd_byte = '0;
    if (reg_read) begin
      unique case (1'b1)
        sel_c2h: begin
          for (int b = 0; b < NB; b++) begin
            if (!c2h_empty && int'(reg_bytecnt) == b)
              rd_byte = c2h_head_word[8*b +: 8];
          end
        end
        sel_h2c: begin
          for (int b = 0; b < NB; b++) begin
            if (int'(reg_bytecnt) == b)
              rd_byte = stage[8*b +: 8];
          end
        end
        sel_st: begin
          case (int'(reg_bytecnt))
            0: rd_byte = {2'b00, unf, ovf,
                          c2h_full, c2h_empty,
                          h2c_full, h2c_empty};
            1: rd_byte = 8'(h2c_cnt);
            2: rd_byte = 8'(c2h_cnt);
            3: rd_byte = 8'(pDEPTH - 1);
            default: rd_byte = '0;
          endcase
        end
        default: rd_byte = '0;
      endcase
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) read_data <= '0;
    else          read_data <= rd_byte;
  end

endmodule
